// File: rtl/frac_sad_select_if.sv
// Handshake bundle between the fractional abs-diff stage, the SAD selector
// and the motion-vector refinement logic.
interface frac_sad_select_if #(
    parameter int PIX_W = 8,
    parameter int COLS  = 6,
    parameter int NCAND = 25,
    parameter int SAD_W = 14,
    parameter int IDX_W = $clog2(NCAND)
);
    logic                         line_valid;
    logic                         line_ready;
    logic [NCAND*COLS*PIX_W-1:0]  diff_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [IDX_W-1:0]             best_idx;
    logic [SAD_W-1:0]             best_sad;

    // Selector side: consumes lines, produces the winning candidate
    modport slave (
        input  line_valid, diff_in, out_ready,
        output line_ready, out_valid, best_idx, best_sad
    );

    // Upstream/downstream side: drives lines, accepts results
    modport master (
        output line_valid, diff_in, out_ready,
        input  line_ready, out_valid, best_idx, best_sad
    );
endinterface

// File: rtl/frac_sad_select.sv
// Fractional SAD selector: accumulates per-candidate SADs over ROWS lines,
// then scans all NCAND sums serially and reports the best candidate.

// Per-candidate line sum and block accumulator.
module frac_sad_acc #(
    parameter int PIX_W = 8,
    parameter int COLS  = 6,
    parameter int SAD_W = 14
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic                    first,
    input  logic [COLS*PIX_W-1:0]   pix,
    output logic [SAD_W-1:0]        line_sum,
    output logic [SAD_W-1:0]        acc
);
    // Sum of the pixel diffs of this candidate on the current line
    always_comb begin
        line_sum = '0;
        for (int j = 0; j < COLS; j++)
            line_sum = line_sum + SAD_W'(pix[j*PIX_W +: PIX_W]);
    end

    // First line of a block overwrites, so no reset is needed here
    always_ff @(posedge clk) begin
        if (load)
            acc <= first ? line_sum : acc + line_sum;
    end
endmodule

module frac_sad_select #(
    parameter int PIX_W = 8,
    parameter int COLS  = 6,
    parameter int ROWS  = 6,
    parameter int NCAND = 25,
    parameter int SAD_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    frac_sad_select_if.slave  bus
);
    localparam int IDX_W = $clog2(NCAND);
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int VEC_W = COLS * PIX_W;
    localparam logic [IDX_W-1:0] CENTRE   = IDX_W'((NCAND - 1) / 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCAND - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {ACCUM, SCAN, DONE} state_t;

    state_t                        state;
    logic [CNT_W-1:0]              line_cnt;
    logic [IDX_W-1:0]              scan_idx;
    logic [IDX_W-1:0]              best_idx_q;
    logic [SAD_W-1:0]              best_sad_q;
    logic                          out_valid_q;
    logic                          accept;
    logic [NCAND-1:0][SAD_W-1:0]   acc_all;
    logic [NCAND-1:0][SAD_W-1:0]   sum_all;
    logic [SAD_W-1:0]              scan_sad;

    // Lines are only taken while accumulating, never during reset
    assign bus.line_ready = (state == ACCUM) && !rst;
    assign accept         = bus.line_valid && bus.line_ready;

    // One accumulator per candidate, all updated in parallel
    for (genvar k = 0; k < NCAND; k++) begin : g_cand
        frac_sad_acc #(
            .PIX_W (PIX_W),
            .COLS  (COLS),
            .SAD_W (SAD_W)
        ) u_acc (
            .clk      (clk),
            .load     (accept),
            .first    (line_cnt == '0),
            .pix      (bus.diff_in[k*VEC_W +: VEC_W]),
            .line_sum (sum_all[k]),
            .acc      (acc_all[k])
        );
    end

    assign scan_sad = acc_all[scan_idx];

    // Block sequencing: accumulate lines, scan candidates, hold result.
    // The scan is seeded with the centre and uses a strict compare, so the
    // centre wins ties against it and otherwise the lowest index wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACCUM;
            line_cnt    <= '0;
            scan_idx    <= '0;
            out_valid_q <= 1'b0;
            best_idx_q  <= CENTRE;
            best_sad_q  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (line_cnt == LAST_ROW) begin
                            line_cnt   <= '0;
                            scan_idx   <= '0;
                            best_idx_q <= CENTRE;
                            best_sad_q <= acc_all[CENTRE] + sum_all[CENTRE];
                            state      <= SCAN;
                        end else begin
                            line_cnt <= line_cnt + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (scan_sad < best_sad_q) begin
                        best_sad_q <= scan_sad;
                        best_idx_q <= scan_idx;
                    end
                    if (scan_idx == LAST_IDX) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.best_idx  = best_idx_q;
    assign bus.best_sad  = best_sad_q;
endmodule
